// File: rtl/spi_slave.sv
// Mode-0, MSB-first SPI slave run entirely from the system clock.
// Pins are oversampled through 2-flop synchronisers; tx words come from a one-entry buffer.
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_abort,
  output logic                  tx_underrun
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] WORD_ZERO = DATA_WIDTH'(0);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [2:0]            sclk_sync_q, sclk_sync_d;
  logic [2:0]            cs_sync_q, cs_sync_d;
  logic [1:0]            mosi_sync_q, mosi_sync_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  reload_q, reload_d;
  logic [DATA_WIDTH-1:0] shift_tx_q, shift_tx_d;
  logic [DATA_WIDTH-1:0] shift_rx_q, shift_rx_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_abort_q, rx_abort_d;
  logic                  tx_underrun_q, tx_underrun_d;
  logic                  word_load_s;
  logic [DATA_WIDTH-1:0] rx_word_s;
  logic                  sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;

  assign sclk_rise_s = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall_s = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise_s   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall_s   = ~cs_sync_q[1] & cs_sync_q[2];

  // Next-state logic for synchronisers, frame FSM, shift registers and tx buffer.
  always_comb begin
    sclk_sync_d   = {sclk_sync_q[1:0], spi_clk};
    cs_sync_d     = {cs_sync_q[1:0], cs};
    mosi_sync_d   = {mosi_sync_q[0], mosi};
    state_d       = state_q;
    cnt_d         = cnt_q;
    reload_d      = reload_q;
    shift_tx_d    = shift_tx_q;
    shift_rx_d    = shift_rx_q;
    rx_data_d     = rx_data_q;
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    rx_valid_d    = 1'b0;
    rx_abort_d    = 1'b0;
    tx_underrun_d = 1'b0;
    word_load_s   = 1'b0;
    rx_word_s     = {shift_rx_q[DATA_WIDTH-2:0], mosi_sync_q[1]};
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (cs_fall_s) begin
          state_d     = ST_ACTIVE;
          word_load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // cs deassertion wins over an spi_clk edge seen in the same cycle
        if (cs_rise_s) begin
          state_d    = ST_IDLE;
          cnt_d      = CNT_ZERO;
          reload_d   = 1'b0;
          shift_rx_d = WORD_ZERO;
          shift_tx_d = WORD_ZERO;
          rx_abort_d = (cnt_q != CNT_ZERO);
        end else if (sclk_rise_s) begin
          shift_rx_d = rx_word_s;
          if (cnt_q == CNT_LAST) begin
            rx_data_d  = rx_word_s;
            rx_valid_d = 1'b1;
            cnt_d      = CNT_ZERO;
            reload_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (sclk_fall_s) begin
          if (reload_q) begin
            word_load_s = 1'b1;
            reload_d    = 1'b0;
          end else begin
            shift_tx_d = {shift_tx_q[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (word_load_s) begin
      if (buf_full_q) begin
        shift_tx_d = buf_q;
        buf_full_d = 1'b0;
      end else begin
        shift_tx_d    = WORD_ZERO;
        tx_underrun_d = 1'b1;
      end
    end else begin
      tx_underrun_d = 1'b0;
    end
    // A load that drains the buffer frees it for a tx_load in the same cycle
    if (tx_load && (!buf_full_q || word_load_s)) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end else begin
      buf_d = buf_q;
    end
  end

  // State register with synchronous reset; cs synchroniser clears low so reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sclk_sync_q   <= 3'b000;
      cs_sync_q     <= 3'b000;
      mosi_sync_q   <= 2'b00;
      cnt_q         <= CNT_ZERO;
      reload_q      <= 1'b0;
      shift_tx_q    <= WORD_ZERO;
      shift_rx_q    <= WORD_ZERO;
      rx_data_q     <= WORD_ZERO;
      buf_q         <= WORD_ZERO;
      buf_full_q    <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_abort_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      cnt_q         <= cnt_d;
      reload_q      <= reload_d;
      shift_tx_q    <= shift_tx_d;
      shift_rx_q    <= shift_rx_d;
      rx_data_q     <= rx_data_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      rx_valid_q    <= rx_valid_d;
      rx_abort_q    <= rx_abort_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign miso        = (state_q == ST_ACTIVE) ? shift_tx_q[DATA_WIDTH-1] : 1'b0;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_abort    = rx_abort_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: stimulus queues expected miso bits and rx words,
// independent monitors pop and compare as the DUT presents them.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_clk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_abort;
  logic       tx_underrun;

  int vectors = 0;
  int miscompares = 0;
  int abort_seen = 0;
  int under_seen = 0;
  int exp_abort = 0;
  int exp_under = 0;
  int wait_n;

  logic       exp_miso[$];
  logic [7:0] exp_rx[$];

  spi_slave #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_abort(rx_abort), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master samples miso on its own rising spi_clk edge
  always @(posedge spi_clk) begin
    if (exp_miso.size() == 0) check("miso_unexpected_bit", 32'd1, 32'd0);
    else check("miso_bit", 32'(miso), 32'(exp_miso.pop_front()));
  end

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      if (exp_rx.size() == 0) check("rx_valid_unexpected", 32'(rx_data), 32'hDEAD);
      else check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
    end
    if (rx_abort === 1'b1) abort_seen++;
    if (tx_underrun === 1'b1) under_seen++;
  end

  task automatic load(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic push_miso(input logic [15:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) exp_miso.push_back(d[i]);
  endtask

  // Mode-0 frame at clk/8; cs rises together with the final spi_clk fall when end_frame is set
  task automatic spi_xfer(input logic [15:0] d, input int n, input bit end_frame);
    @(negedge clk);
    cs = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = d[i];
      repeat (4) @(negedge clk);
      spi_clk = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk = 1'b0;
      if (i == 0 && end_frame) cs = 1'b1;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_abort_count"}, 32'(abort_seen), 32'(exp_abort));
    check({tag, "_underrun_count"}, 32'(under_seen), 32'(exp_under));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cs = 1'b1; spi_clk = 1'b0; mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_miso", 32'(miso), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_tx_ready", 32'(tx_ready), 32'd1);
    check("reset_pulses", {29'd0, rx_valid, rx_abort, tx_underrun}, 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Basic exchange
    load(8'hA5);
    check("basic_ready_low", 32'(tx_ready), 32'd0);
    push_miso(16'h00A5, 8);
    exp_rx.push_back(8'h3C);
    spi_xfer(16'h003C, 8, 1'b1);
    check("basic_ready_back", 32'(tx_ready), 32'd1);
    check("basic_rx_hold", 32'(rx_data), 32'h3C);
    check_pulses("basic");

    // Back-to-back words in one frame, second word loaded once the buffer drains
    load(8'h81);
    push_miso(16'h817E, 16);
    exp_rx.push_back(8'h11);
    exp_rx.push_back(8'h22);
    fork
      spi_xfer(16'h1122, 16, 1'b1);
      begin
        wait_n = 0;
        while (tx_ready !== 1'b1 && wait_n < 200) begin
          @(negedge clk);
          wait_n++;
        end
        check("b2b_ready_wait", 32'(tx_ready), 32'd1);
        load(8'h7E);
      end
    join
    check_pulses("b2b");

    // Underrun
    push_miso(16'h0000, 8);
    exp_rx.push_back(8'hFF);
    exp_under++;
    spi_xfer(16'h00FF, 8, 1'b1);
    check_pulses("underrun");

    // Abort after 5 bits of 0xC3 (sends 11000)
    push_miso(16'h0000, 5);
    exp_under++;
    exp_abort++;
    spi_xfer(16'h0018, 5, 1'b1);
    check("abort_rx_kept", 32'(rx_data), 32'hFF);
    check_pulses("abort");
    push_miso(16'h0000, 8);
    exp_rx.push_back(8'h5A);
    exp_under++;
    spi_xfer(16'h005A, 8, 1'b1);
    check_pulses("after_abort");

    // Load collision: second load while full is ignored
    load(8'h12);
    check("collision_ready_low", 32'(tx_ready), 32'd0);
    load(8'h34);
    push_miso(16'h0012, 8);
    exp_rx.push_back(8'h00);
    spi_xfer(16'h0000, 8, 1'b1);
    check_pulses("collision");

    // Mid-frame reset after 3 bits
    load(8'hF0);
    push_miso(16'h0007, 3);
    spi_xfer(16'h0005, 3, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_miso", 32'(miso), 32'd0);
    check("midreset_rx_data", 32'(rx_data), 32'h00);
    check("midreset_tx_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    cs = 1'b1;
    repeat (8) @(negedge clk);
    check("postreset_pulses", {29'd0, rx_valid, rx_abort, tx_underrun}, 32'd0);
    check_pulses("midreset");
    load(8'h96);
    push_miso(16'h0096, 8);
    exp_rx.push_back(8'h69);
    spi_xfer(16'h0069, 8, 1'b1);
    check("postreset_rx", 32'(rx_data), 32'h69);
    check_pulses("postreset");

    repeat (4) @(negedge clk);
    check("miso_queue_drained", 32'(exp_miso.size()), 32'd0);
    check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
